// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// At most one read is in flight; a fetch starved by data traffic is promoted.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [31:0]     if_rdata,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [3:0]      d_be,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,

    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,

    output logic            stall_if,
    output logic            stall_mem,
    output logic            err_spurious
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, RD_IF, RD_D} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] starve_cnt_reg, starve_cnt_next;
    logic          hold_valid_reg, hold_if_reg;
    logic          err_reg;

    logic can_issue;
    logic sel_if;
    logic accept;
    logic is_read;

    // A new transfer may start when idle, or when the outstanding read returns this cycle.
    assign can_issue = (state_reg == IDLE) || mem_rvalid;

    // An offered-but-unaccepted requester keeps the port until it is granted.
    always_comb begin
        sel_if = 1'b0;
        if (hold_valid_reg && (hold_if_reg ? if_req : d_req))
            sel_if = hold_if_reg;
        else if (if_req && (starve_cnt_reg == STARVE_MAX))
            sel_if = 1'b1;
        else
            sel_if = if_req && !d_req;
    end

    assign mem_req   = reset && can_issue && (if_req || d_req);
    assign accept    = mem_req && mem_gnt;
    assign if_gnt    = accept && sel_if;
    assign d_gnt     = accept && !sel_if;
    assign is_read   = sel_if || !d_we;

    assign mem_we    = sel_if ? 1'b0  : d_we;
    assign mem_be    = sel_if ? 4'hF  : d_be;
    assign mem_addr  = sel_if ? if_addr : d_addr;
    assign mem_wdata = sel_if ? '0    : d_wdata;

    assign if_rvalid = (state_reg == RD_IF) && mem_rvalid;
    assign d_rvalid  = (state_reg == RD_D)  && mem_rvalid;
    assign if_rdata  = if_rvalid ? 32'(mem_rdata) : 32'h0;
    assign d_rdata   = d_rvalid  ? mem_rdata      : '0;

    assign stall_if     = if_req && !if_rvalid;
    assign stall_mem    = d_req && !(d_we ? d_gnt : d_rvalid);
    assign err_spurious = err_reg;

    always_comb begin
        state_next = state_reg;
        if ((state_reg != IDLE) && mem_rvalid)
            state_next = IDLE;
        if (accept && is_read)
            state_next = sel_if ? RD_IF : RD_D;
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!if_req || if_gnt)
            starve_cnt_next = '0;
        else if (d_gnt && (starve_cnt_reg != STARVE_MAX))
            starve_cnt_next = starve_cnt_reg + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            hold_valid_reg <= 1'b0;
            hold_if_reg    <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            hold_valid_reg <= mem_req && !mem_gnt;
            hold_if_reg    <= sel_if;
            // A response with nothing outstanding is dropped and flagged until reset.
            if ((state_reg == IDLE) && mem_rvalid)
                err_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reset-state vector table, directed
// multi-cycle scenarios and randomized traffic against a transaction-level model.
module tb_mem_arbiter;
    localparam int XLEN   = 32;
    localparam int STARVE = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt, if_rvalid;
    logic [31:0]     if_rdata;
    logic            d_req, d_we;
    logic [3:0]      d_be;
    logic [XLEN-1:0] d_addr, d_wdata;
    logic            d_gnt, d_rvalid;
    logic [XLEN-1:0] d_rdata;
    logic            mem_req, mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic            mem_gnt, mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            stall_if, stall_mem, err_spurious;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .err_spurious(err_spurious)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: who owns the outstanding read (0 none, 1 fetch, 2 data),
    // who was offered the port but not yet accepted, and how many arbitrations fetch lost.
    int m_owner, m_pend, m_starved;
    bit m_err;
    int e_who;
    bit e_mem_req, e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_read;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        m_owner = 0; m_pend = 0; m_starved = 0; m_err = 0;
    endtask

    task automatic model_eval();
        bit can;
        if (!reset) model_clear();
        can = (m_owner == 0) || mem_rvalid;
        if (m_pend == 1 && if_req)              e_who = 1;
        else if (m_pend == 2 && d_req)          e_who = 2;
        else if (if_req && m_starved >= STARVE) e_who = 1;
        else if (d_req)                         e_who = 2;
        else if (if_req)                        e_who = 1;
        else                                    e_who = 0;
        e_mem_req = reset && can && (e_who != 0);
        e_if_gnt  = e_mem_req && mem_gnt && (e_who == 1);
        e_d_gnt   = e_mem_req && mem_gnt && (e_who == 2);
        e_read    = (e_who == 1) || !d_we;
        e_if_rv   = reset && (m_owner == 1) && mem_rvalid;
        e_d_rv    = reset && (m_owner == 2) && mem_rvalid;
    endtask

    task automatic model_update();
        if (!reset) begin
            model_clear();
            return;
        end
        if (mem_rvalid) begin
            if (m_owner == 0) m_err = 1;
            m_owner = 0;
        end
        if ((e_if_gnt || e_d_gnt) && e_read) m_owner = e_who;
        m_pend = (e_mem_req && !mem_gnt) ? e_who : 0;
        if (!if_req || e_if_gnt)  m_starved = 0;
        else if (e_d_gnt)         m_starved = (m_starved < STARVE) ? m_starved + 1 : STARVE;
    endtask

    // Settle after the inputs changed on the falling edge and compare everything.
    task automatic settle();
        #1;
        model_eval();
        chk("mem_req",   mem_req,   e_mem_req);
        chk("if_gnt",    if_gnt,    e_if_gnt);
        chk("d_gnt",     d_gnt,     e_d_gnt);
        chk("if_rvalid", if_rvalid, e_if_rv);
        chk("d_rvalid",  d_rvalid,  e_d_rv);
        chk("if_rdata",  if_rdata,  e_if_rv ? mem_rdata : 32'h0);
        chk("d_rdata",   d_rdata,   e_d_rv ? mem_rdata : 32'h0);
        chk("stall_if",  stall_if,  if_req && !e_if_rv);
        chk("stall_mem", stall_mem, d_req && !(d_we ? e_d_gnt : e_d_rv));
        chk("err_spurious", err_spurious, m_err);
        if (e_mem_req) begin
            chk("mem_we",    mem_we,    (e_who == 1) ? 1'b0 : d_we);
            chk("mem_be",    mem_be,    (e_who == 1) ? 4'hF : d_be);
            chk("mem_addr",  mem_addr,  (e_who == 1) ? if_addr : d_addr);
            chk("mem_wdata", mem_wdata, (e_who == 1) ? 32'h0 : d_wdata);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0;
        d_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 0;
        idle_inputs();
        settle();
        advance();
        reset = 1;
    endtask

    typedef struct {
        logic ir, dr, dwe; logic [3:0] dbe; logic gnt, rv;
        logic x_req, x_we; logic [3:0] x_be; logic [31:0] x_addr;
        logic x_ig, x_dg, x_si, x_sm, x_err_after;
    } vec_t;

    vec_t tbl [10];
    bit   last_if_gnt, last_d_gnt;
    int   n_xfer;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 0;
        idle_inputs();
        model_clear();
        // ir dr dwe be gnt rv | req we be addr ig dg si sm err_after  (fetch at 0x40, data at 0x100)
        tbl[0] = '{0,0,0,4'h0,1,0, 0,0,4'h0,32'h0,   0,0,0,0,0};
        tbl[1] = '{1,0,0,4'h0,0,0, 1,0,4'hF,32'h40,  0,0,1,0,0};
        tbl[2] = '{1,0,0,4'h0,1,0, 1,0,4'hF,32'h40,  1,0,1,0,0};
        tbl[3] = '{0,1,0,4'hF,1,0, 1,0,4'hF,32'h100, 0,1,0,1,0};
        tbl[4] = '{0,1,1,4'h3,1,0, 1,1,4'h3,32'h100, 0,1,0,0,0};
        tbl[5] = '{0,1,1,4'h3,0,0, 1,1,4'h3,32'h100, 0,0,0,1,0};
        tbl[6] = '{1,1,0,4'hF,1,0, 1,0,4'hF,32'h100, 0,1,1,1,0};
        tbl[7] = '{1,1,1,4'hC,1,0, 1,1,4'hC,32'h100, 0,1,1,0,0};
        tbl[8] = '{0,0,0,4'h0,0,1, 0,0,4'h0,32'h0,   0,0,0,0,1};
        tbl[9] = '{1,0,0,4'h0,1,1, 1,0,4'hF,32'h40,  1,0,1,0,1};

        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            do_reset();
            if_req = tbl[i].ir; if_addr = 32'h40;
            d_req = tbl[i].dr; d_we = tbl[i].dwe; d_be = tbl[i].dbe;
            d_addr = 32'h100; d_wdata = 32'hCAFE0000;
            mem_gnt = tbl[i].gnt; mem_rvalid = tbl[i].rv; mem_rdata = 32'h12345678;
            #1;
            chk("tbl_mem_req",   mem_req,   tbl[i].x_req);
            chk("tbl_if_gnt",    if_gnt,    tbl[i].x_ig);
            chk("tbl_d_gnt",     d_gnt,     tbl[i].x_dg);
            chk("tbl_stall_if",  stall_if,  tbl[i].x_si);
            chk("tbl_stall_mem", stall_mem, tbl[i].x_sm);
            chk("tbl_rvalids",   {if_rvalid, d_rvalid}, 2'b00);
            chk("tbl_rdata",     {if_rdata, d_rdata}, 64'h0);
            if (tbl[i].x_req) begin
                chk("tbl_mem_we",    mem_we,    tbl[i].x_we);
                chk("tbl_mem_be",    mem_be,    tbl[i].x_be);
                chk("tbl_mem_addr",  mem_addr,  tbl[i].x_addr);
                chk("tbl_mem_wdata", mem_wdata, (tbl[i].x_addr == 32'h40) ? 32'h0 : 32'hCAFE0000);
            end
            @(posedge clk);
            #1;
            chk("tbl_err_after", err_spurious, tbl[i].x_err_after);
            @(negedge clk);
            $display("vector %0d: if_req=%0b d_req=%0b d_we=%0b gnt=%0b rvalid=%0b",
                     i, tbl[i].ir, tbl[i].dr, tbl[i].dwe, tbl[i].gnt, tbl[i].rv);
        end

        // Fetch with a one-cycle memory response.
        do_reset();
        if_req = 1; if_addr = 32'h40; mem_gnt = 1;
        settle(); chk("r27_if_gnt", if_gnt, 1'b1); advance();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
        settle();
        chk("r27_if_rvalid", if_rvalid, 1'b1);
        chk("r27_if_rdata",  if_rdata,  32'h00500093);
        chk("r27_stall_if",  stall_if,  1'b0);
        advance();
        idle_inputs(); settle(); advance();
        $display("scenario fetch: addr=0x40 data=0x00500093");

        // Simultaneous load and fetch: data first, fetch in the load's response cycle.
        do_reset();
        if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h100; mem_gnt = 1;
        settle(); chk("r28_d_first", {d_gnt, if_gnt}, 2'b10); advance();
        d_req = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_0001;
        settle(); chk("r28_d_rvalid", d_rvalid, 1'b1); chk("r28_if_gnt", if_gnt, 1'b1); advance();
        if_req = 0; mem_rdata = 32'hA5A5_0002;
        settle(); chk("r28_if_rvalid", if_rvalid, 1'b1); advance();
        idle_inputs(); settle(); advance();
        $display("scenario load+fetch: back-to-back");

        // Back-to-back stores starving a fetch.
        do_reset();
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h300; d_wdata = 32'h1111;
        if_req = 1; if_addr = 32'h80; mem_gnt = 1;
        for (int k = 0; k < STARVE; k++) begin
            settle(); chk("r29_d_gnt", {d_gnt, if_gnt}, 2'b10); advance();
        end
        settle(); chk("r29_if_gnt", {d_gnt, if_gnt}, 2'b01); advance();
        for (int k = 0; k < STARVE; k++) begin
            mem_rvalid = (k == 0);
            settle(); chk("r29_d_gnt_again", {d_gnt, if_gnt}, 2'b10); advance();
        end
        mem_rvalid = 0;
        settle(); chk("r29_if_gnt_again", {d_gnt, if_gnt}, 2'b01); advance();
        idle_inputs(); mem_rvalid = 1; settle(); chk("r29_if_rvalid", if_rvalid, 1'b1); advance();
        mem_rvalid = 0; settle(); advance();
        $display("scenario starvation: fetch promoted after %0d stores", STARVE);

        // Store held off by the memory for three cycles.
        do_reset();
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h88; d_wdata = 32'hDEADBEEF; mem_gnt = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("r30_mem_fields", {mem_req, mem_we, mem_be, mem_addr, mem_wdata},
                {1'b1, 1'b1, 4'b0011, 32'h88, 32'hDEADBEEF});
            chk("r30_no_gnt", d_gnt, 1'b0);
            advance();
        end
        mem_gnt = 1;
        settle(); chk("r30_d_gnt", d_gnt, 1'b1); advance();
        d_req = 0; if_req = 1; if_addr = 32'h90;
        settle(); chk("r30_idle_after", {if_gnt, d_rvalid}, 2'b10); advance();
        idle_inputs(); mem_rvalid = 1; settle(); advance();
        idle_inputs(); settle(); advance();
        $display("scenario stalled store: 0xDEADBEEF be=0011");

        // A pending fetch is not preempted by a later load.
        do_reset();
        if_req = 1; if_addr = 32'h44; mem_gnt = 0;
        settle(); advance();
        d_req = 1; d_we = 0; d_addr = 32'h104;
        settle(); chk("hold_addr", mem_addr, 32'h44); advance();
        mem_gnt = 1;
        settle(); chk("hold_if_gnt", {d_gnt, if_gnt}, 2'b01); advance();
        if_req = 0;
        settle(); chk("hold_busy", mem_req, 1'b0); advance();
        mem_rvalid = 1;
        settle(); chk("hold_d_next", d_gnt, 1'b1); advance();
        d_req = 0;
        settle(); chk("hold_d_rvalid", d_rvalid, 1'b1); advance();
        idle_inputs(); settle(); advance();
        $display("scenario hold: fetch kept the port");

        // Reset in the middle of a load, then a stale response.
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h100; mem_gnt = 1;
        settle(); advance();
        d_req = 0; mem_gnt = 0; reset = 0;
        settle(); chk("r31_in_reset", {if_gnt, d_gnt, if_rvalid, d_rvalid}, 4'h0); advance();
        reset = 1; mem_rvalid = 1; mem_rdata = 32'hBAD;
        settle(); chk("r31_no_d_rvalid", d_rvalid, 1'b0); advance();
        mem_rvalid = 0;
        for (int k = 0; k < 3; k++) begin
            settle(); chk("r31_err_sticky", err_spurious, 1'b1); advance();
        end
        do_reset();
        settle(); chk("r31_err_cleared", err_spurious, 1'b0); advance();
        $display("scenario reset mid-read: stale response flagged");

        // Response with nothing outstanding.
        do_reset();
        mem_rvalid = 1;
        settle(); chk("r32_rvalids", {if_rvalid, d_rvalid}, 2'b00); advance();
        mem_rvalid = 0;
        settle(); chk("r32_err", err_spurious, 1'b1); advance();
        $display("scenario spurious response: flagged");

        // Randomized traffic against the model.
        do_reset();
        last_if_gnt = 0; last_d_gnt = 0; n_xfer = 0;
        for (int c = 0; c < 800; c++) begin
            if (!if_req || last_if_gnt) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req || last_d_gnt) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_we    = ($urandom_range(0, 2) != 0);
                d_be    = 4'($urandom);
                d_addr  = $urandom & 32'hFFFF_FFFC;
                d_wdata = $urandom;
            end
            mem_gnt    = ($urandom_range(0, 3) != 0);
            mem_rvalid = (m_owner != 0) && ($urandom_range(0, 1) == 1);
            mem_rdata  = $urandom;
            settle();
            last_if_gnt = e_if_gnt;
            last_d_gnt  = e_d_gnt;
            if (e_if_gnt || e_d_gnt) begin
                n_xfer++;
                $display("xfer %0d: %s addr=%08h", n_xfer,
                         e_if_gnt ? "fetch" : (d_we ? "store" : "load"),
                         e_if_gnt ? if_addr : d_addr);
            end
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
